// File: rtl/nbit_arith_pkg.sv
// Shared definitions for the N-bit arithmetic datapath blocks (divider FSM states,
// default operand width and the iteration-counter width helper).
package nbit_arith_pkg;

    localparam int DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nbit_seq_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the sequential divider.
interface nbit_seq_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/nbit_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the result if non-negative.
module nbit_div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   r_i,
    input  logic         q_msb_i,
    input  logic [N-1:0] d_i,
    output logic [N:0]   r_o,
    output logic         q_bit_o
);
    logic [N:0] t;
    logic [N:0] d_ext;
    logic       unused_r_msb;

    // The stored remainder is always below the divisor, so its top bit never
    // carries information into the shift.
    assign unused_r_msb = r_i[N];
    assign t            = {r_i[N-1:0], q_msb_i};
    assign d_ext        = {1'b0, d_i};
    assign q_bit_o      = (t >= d_ext);
    assign r_o          = q_bit_o ? (t - d_ext) : t;
endmodule

// File: rtl/nbit_seq_divider.sv
// Sequential N-bit unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero reported alongside the results.
module nbit_seq_divider
    import nbit_arith_pkg::*;
#(
    parameter int N = DIV_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    nbit_seq_divider_if.slave bus
);
    localparam int            CW        = cnt_width(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    div_state_e    state_q, state_d;
    logic [N:0]    r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic          zero_op_q, zero_op_d;
    logic          accept;
    logic [N:0]    step_r;
    logic          step_bit;

    nbit_div_step #(.N(N)) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[N-1]),
        .d_i     (d_q),
        .r_o     (step_r),
        .q_bit_o (step_bit)
    );

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dz_d      = dz_q;
        zero_op_d = zero_op_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: accept = bus.start;
            ST_CALC: begin
                r_d   = step_r;
                q_d   = {q_q[N-2:0], step_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    if (zero_op_q) begin
                        quo_d = '1;
                        rem_d = q_q;
                        dz_d  = 1'b1;
                    end else begin
                        quo_d = {q_q[N-2:0], step_bit};
                        rem_d = step_r[N-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = bus.start;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d   = ST_CALC;
            q_d       = bus.dividend;
            d_d       = bus.divisor;
            r_d       = '0;
            dz_d      = 1'b0;
            zero_op_d = (bus.divisor == '0);
            // A zero divisor makes a single pass so its results land on the
            // same schedule as a one-step operation; Q still holds the dividend.
            cnt_d     = (bus.divisor == '0) ? LAST_STEP : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
            zero_op_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dz_q      <= dz_d;
            zero_op_q <= zero_op_d;
        end
    end

    assign bus.busy        = (state_q == ST_CALC);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
endmodule
